mode_select: RTL and testbench

- Front-panel mode controller that produces the frequency mode (3-bit) and modulation mode (2-bit) codes.
- These codes drive the 7-segment display controller and the DAC sample-rate and PAM symbol logic.
- Takes three raw active-low pushbuttons, synchronizes and debounces each one, and turns each debounced press into a single mode step.
- Emits a one-cycle pulse whenever either mode changes.

---
 rtl/mode_select.sv | 159 +++++++++++++++
 tb/tb_mode_select.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_select.sv
// mode_select: front-panel mode controller.
// Three raw active-low buttons are synchronized and debounced. Each accepted
// press steps the frequency mode (fmode, up/down with wrap) or the
// modulation mode (mmode, next with wrap). mode_update pulses for one cycle
// in the same cycle a mode register takes a new value.
// Optional build macro HOLD_REPEAT_EN: a button held down keeps generating
// extra presses every REPEAT_CYCLES cycles. Without the macro, no repeat
// logic is built and REPEAT_CYCLES has no effect.
module mode_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_fup_n,
    input  logic       key_fdn_n,
    input  logic       key_mod_n,
    output logic [2:0] fmode,
    output logic [1:0] mmode,
    output logic       mode_update
);

    // Debounce counter width. DEBOUNCE_CYCLES is at least 2, so this is >= 1.
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    // Button order used throughout: 0 = freq up, 1 = freq down, 2 = mod next.
    logic [2:0] key_n;
    logic [2:0] step;

    assign key_n = {key_mod_n, key_fdn_n, key_fup_n};

`ifdef HOLD_REPEAT_EN
    localparam int unsigned RCW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);
`else
    // Repeat period has no role without auto-repeat; reduced here so it
    // reads as deliberately unused.
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    for (genvar i = 0; i < 3; i++) begin : g_key
        logic           s1;
        logic           s2;
        logic           deb;
        logic [DCW-1:0] cnt;
        logic           accept;
        logic           fall;
        logic           rep_hit;
        logic           step_q;

        // The synchronized level has disagreed with the debounced level for
        // DEBOUNCE_CYCLES consecutive edges: take it this edge.
        assign accept = (s2 != deb) && (cnt == DEB_LAST);
        // Only the released-to-pressed transition counts as a press.
        assign fall   = accept && !s2;

        // Two-flop synchronizer; idles at released (1).
        always_ff @(posedge clk) begin
            if (rst) begin
                s1 <= 1'b1;
                s2 <= 1'b1;
            end else begin
                s1 <= key_n[i];
                s2 <= s1;
            end
        end

        // Debounce: count edges of disagreement, restart on any bounce back.
        always_ff @(posedge clk) begin
            if (rst) begin
                deb <= 1'b1;
                cnt <= '0;
            end else if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

`ifdef HOLD_REPEAT_EN
        logic [RCW-1:0] rcnt;

        // Fires once every REPEAT_CYCLES edges while the button stays pressed.
        assign rep_hit = !deb && (rcnt == REP_LAST);

        // Hold-time counter: runs only while pressed, cleared on release.
        always_ff @(posedge clk) begin
            if (rst || deb) begin
                rcnt <= '0;
            end else if (rep_hit) begin
                rcnt <= '0;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
`else
        assign rep_hit = 1'b0;
`endif

        // One-cycle press strobe, consumed by the mode registers next edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                step_q <= 1'b0;
            end else begin
                step_q <= fall || rep_hit;
            end
        end

        assign step[i] = step_q;
    end

    logic       up;
    logic       dn;
    logic       md;
    logic [2:0] fmode_next;
    logic [1:0] mmode_next;
    logic       change;

    assign up = step[0];
    assign dn = step[1];
    assign md = step[2];

    // Next mode values; simultaneous up and down cancel each other.
    always_comb begin
        fmode_next = fmode;
        mmode_next = mmode;
        change     = 1'b0;
        if (up && !dn) begin
            fmode_next = fmode + 3'd1;
            change     = 1'b1;
        end else if (dn && !up) begin
            fmode_next = fmode - 3'd1;
            change     = 1'b1;
        end
        if (md) begin
            mmode_next = mmode + 2'd1;
            change     = 1'b1;
        end
    end

    // Registered mode outputs and the change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fmode       <= 3'd0;
            mmode       <= 2'd0;
            mode_update <= 1'b0;
        end else begin
            fmode       <= fmode_next;
            mmode       <= mmode_next;
            mode_update <= change;
        end
    end

endmodule

// File: tb/tb_mode_select.sv
// Bench for mode_select with short debounce/repeat periods.
module tb_mode_select;

    localparam int DEB = 4;
    localparam int REP = 10;

    logic       clk;
    logic       rst;
    logic       key_fup_n;
    logic       key_fdn_n;
    logic       key_mod_n;
    logic [2:0] fmode;
    logic [1:0] mmode;
    logic       mode_update;

    int total = 0;
    int bad   = 0;

    mode_select #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_fup_n  (key_fup_n),
        .key_fdn_n  (key_fdn_n),
        .key_mod_n  (key_mod_n),
        .fmode      (fmode),
        .mmode      (mmode),
        .mode_update(mode_update)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Raw samples enter a 2-deep delay queue (the synchronizer latency).
    // A level is accepted after DEB consecutive disagreeing samples; an
    // accepted press moves the modes on the following edge.
    logic [2:0] raw_q[$];
    bit   [2:0] m_deb;
    int         m_run[3];
    int         m_hold[3];
    bit   [2:0] m_pend;
    logic [2:0] exp_f;
    logic [1:0] exp_m;
    logic       exp_u;

    always @(posedge clk) begin : ref_model
        logic [2:0] seen;
        logic [2:0] newp;
        if (rst) begin
            raw_q.delete();
            raw_q.push_back(3'b111);
            raw_q.push_back(3'b111);
            m_deb  = 3'b111;
            m_pend = 3'b000;
            for (int i = 0; i < 3; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
            exp_f = 3'd0;
            exp_m = 2'd0;
            exp_u = 1'b0;
        end else begin
            exp_u = ((m_pend[0] != m_pend[1]) || m_pend[2]);
            if (m_pend[0] && !m_pend[1]) exp_f = 3'((int'(exp_f) + 1) % 8);
            if (m_pend[1] && !m_pend[0]) exp_f = 3'((int'(exp_f) + 7) % 8);
            if (m_pend[2])               exp_m = 2'((int'(exp_m) + 1) % 4);
            seen = raw_q.pop_front();
            raw_q.push_back({key_mod_n, key_fdn_n, key_fup_n});
            newp = 3'b000;
            for (int i = 0; i < 3; i++) begin
`ifdef HOLD_REPEAT_EN
                if (!m_deb[i]) begin
                    m_hold[i]++;
                    if (m_hold[i] == REP) begin
                        newp[i]   = 1'b1;
                        m_hold[i] = 0;
                    end
                end else begin
                    m_hold[i] = 0;
                end
`endif
                if (seen[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = seen[i];
                        m_run[i] = 0;
                        if (!seen[i]) newp[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend = newp;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_keys(input logic [2:0] low_mask);
        key_fup_n = ~low_mask[0];
        key_fdn_n = ~low_mask[1];
        key_mod_n = ~low_mask[2];
    endtask

    task automatic press(input logic [2:0] mask, input int low_cyc, input int high_cyc);
        set_keys(mask);
        repeat (low_cyc) @(negedge clk);
        set_keys(3'b000);
        repeat (high_cyc) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(3);
        total++;
        if (fmode !== 3'd0) begin bad++; $display("FAIL reset_fmode got=%0d want=0", fmode); end
        total++;
        if (mmode !== 2'd0) begin bad++; $display("FAIL reset_mmode got=%0d want=0", mmode); end
        total++;
        if (mode_update !== 1'b0) begin bad++; $display("FAIL reset_update got=%b want=0", mode_update); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_press();
        int pulses = 0;
        int pedge  = -1;
        set_keys(3'b001);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mode_update === 1'b1) begin
                pulses++;
                pedge = k;
            end
        end
        set_keys(3'b000);
        repeat (12) @(negedge clk);
        total++;
        if (pulses != 1) begin bad++; $display("FAIL single_pulses got=%0d want=1", pulses); end
        total++;
        if (pedge != DEB + 3) begin bad++; $display("FAIL single_latency got=%0d want=%0d", pedge, DEB + 3); end
        total++;
        if (fmode !== 3'd1) begin bad++; $display("FAIL single_fmode got=%0d want=1", fmode); end
        total++;
        if (fmode !== exp_f) begin bad++; $display("FAIL single_model got=%0d want=%0d", fmode, exp_f); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int r = 0; r < 5; r++) begin
            set_keys(3'b100);
            repeat (3) begin
                @(negedge clk);
                if (mode_update === 1'b1) pulses++;
            end
            set_keys(3'b000);
            repeat (4) begin
                @(negedge clk);
                if (mode_update === 1'b1) pulses++;
            end
        end
        repeat (6) begin
            @(negedge clk);
            if (mode_update === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses); end
        total++;
        if (mmode !== 2'd0) begin bad++; $display("FAIL glitch_mmode got=%0d want=0", mmode); end
        press(3'b100, 10, 12);
        total++;
        if (mmode !== 2'd1) begin bad++; $display("FAIL clean_mmode got=%0d want=1", mmode); end
    endtask

    task automatic test_wrap();
        logic [1:0] seq[4];
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
        do_reset(2);
        press(3'b010, 10, 12);
        total++;
        if (fmode !== 3'd7) begin bad++; $display("FAIL wrap_down got=%0d want=7", fmode); end
        press(3'b001, 10, 12);
        total++;
        if (fmode !== 3'd0) begin bad++; $display("FAIL wrap_up got=%0d want=0", fmode); end
        for (int i = 0; i < 4; i++) begin
            press(3'b100, 10, 12);
            total++;
            if (mmode !== seq[i]) begin bad++; $display("FAIL mod_seq%0d got=%0d want=%0d", i, mmode, seq[i]); end
        end
    endtask

    task automatic test_cancel();
        int pulses = 0;
        set_keys(3'b011);
        repeat (20) begin
            @(negedge clk);
            if (mode_update === 1'b1) pulses++;
        end
        set_keys(3'b000);
        repeat (12) begin
            @(negedge clk);
            if (mode_update === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL cancel_pulses got=%0d want=0", pulses); end
        total++;
        if (fmode !== 3'd0) begin bad++; $display("FAIL cancel_fmode got=%0d want=0", fmode); end
        pulses = 0;
        set_keys(3'b101);
        repeat (20) begin
            @(negedge clk);
            if (mode_update === 1'b1) pulses++;
        end
        set_keys(3'b000);
        repeat (12) @(negedge clk);
        total++;
        if (pulses != 1) begin bad++; $display("FAIL both_pulses got=%0d want=1", pulses); end
        total++;
        if ({fmode, mmode} !== {3'd1, 2'd1}) begin
            bad++; $display("FAIL both_modes got=%0d/%0d want=1/1", fmode, mmode);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int pedge  = -1;
        set_keys(3'b001);
        repeat (4) @(negedge clk);
        do_reset(1);
        total++;
        if ({fmode, mmode, mode_update} !== 6'd0) begin
            bad++; $display("FAIL midreset_out got=%0d/%0d/%b want=0/0/0", fmode, mmode, mode_update);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mode_update === 1'b1) begin
                pulses++;
                pedge = k;
            end
        end
        set_keys(3'b000);
        repeat (12) @(negedge clk);
        total++;
        if (pulses != 1 || pedge != DEB + 3) begin
            bad++; $display("FAIL midreset_press pulses=%0d edge=%0d want 1 at %0d", pulses, pedge, DEB + 3);
        end
        total++;
        if (fmode !== 3'd1) begin bad++; $display("FAIL midreset_fmode got=%0d want=1", fmode); end
    endtask

    task automatic test_hold();
        int pulses = 0;
        int last   = -1;
`ifdef HOLD_REPEAT_EN
        int         want_p = 4;
        int         want_l = 37;
        logic [2:0] want_f = 3'd4;
`else
        int         want_p = 1;
        int         want_l = 7;
        logic [2:0] want_f = 3'd1;
`endif
        do_reset(2);
        set_keys(3'b001);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 38) set_keys(3'b000);
            if (mode_update === 1'b1) begin
                pulses++;
                last = k;
            end
        end
        total++;
        if (pulses != want_p || last != want_l) begin
            bad++; $display("FAIL hold_steps pulses=%0d last=%0d want %0d last %0d", pulses, last, want_p, want_l);
        end
        total++;
        if (fmode !== want_f) begin bad++; $display("FAIL hold_fmode got=%0d want=%0d", fmode, want_f); end
    endtask

    task automatic test_random();
        int         left[3];
        logic [2:0] lvl;
        int         errs = 0;
        lvl = 3'b000;
        for (int i = 0; i < 3; i++) left[i] = $urandom_range(1, 9);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    lvl[i]  = ~lvl[i];
                    left[i] = $urandom_range(1, 9);
                end
            end
            set_keys(lvl);
            rst = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            total++;
            if ({fmode, mmode, mode_update} !== {exp_f, exp_m, exp_u}) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d got=%0d/%0d/%b want=%0d/%0d/%b",
                             c, fmode, mmode, mode_update, exp_f, exp_m, exp_u);
            end
        end
        rst = 1'b0;
        set_keys(3'b000);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        set_keys(3'b000);
        @(negedge clk);
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_cancel();
        test_reset_mid();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
